// File: rtl/wb_packer_if.sv
// Stream bundle between the compute engine, the write-back packer and the DMA.
// The packer sits on the slave side; the engine/DMA environment is the master.
interface wb_packer_if #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 10
);
  logic                   in_valid;
  logic [15:0]            in_data;
  logic                   flush;
  logic                   o_valid;
  logic                   o_ready;
  logic [16*BURST_LEN-1:0] o_data;
  logic [ADDR_W-1:0]      o_addr;
  logic [BURST_LEN-1:0]   o_mask;

  modport master (
    output in_valid, in_data, flush, o_ready,
    input  o_valid, o_data, o_addr, o_mask
  );

  modport slave (
    input  in_valid, in_data, flush, o_ready,
    output o_valid, o_data, o_addr, o_mask
  );
endinterface

// File: rtl/wb_packer.sv
// Packs the engine's serial FP16 result stream into BURST_LEN-lane RAM words and queues
// them with write addresses for the DMA; the small FIFO isolates the non-stallable engine.
module wb_packer #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_addr,
  wb_packer_if.slave        bus,
  output logic              overflow,
  output logic              done,
  output logic [15:0]       word_count
);
  localparam int LANE_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 16 * BURST_LEN;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [LANE_W-1:0]    lane;
  logic [DATA_W-1:0]    pack_data, merged_data, stage_data;
  logic [BURST_LEN-1:0] pack_mask, merged_mask, stage_mask;
  logic                 stage_valid, stage_flush;
  logic                 beat, complete, flush_take, load_stage;

  logic [DATA_W-1:0]    mem_data [DEPTH];
  logic [ADDR_W-1:0]    mem_addr [DEPTH];
  logic [BURST_LEN-1:0] mem_mask [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [ADDR_W-1:0]    addr;
  logic                 fifo_empty, fifo_full, pop, push_ok;

  // Merge the current beat into a copy of the pack register so flush sees the beat first.
  always_comb begin
    merged_data = pack_data;
    merged_mask = pack_mask;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (beat && lane == LANE_W'(i)) begin
        merged_data[i*16 +: 16] = bus.in_data;
        merged_mask[i]          = 1'b1;
      end
    end
  end

  assign beat       = bus.in_valid;
  assign complete   = beat && (lane == LAST_LANE);
  assign flush_take = bus.flush && (state != DRAIN);
  assign load_stage = complete || (flush_take && (|merged_mask));

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign pop        = bus.o_valid && bus.o_ready;
  assign push_ok    = stage_valid && (!fifo_full || pop);

  assign bus.o_valid = !fifo_empty;
  assign bus.o_data  = fifo_empty ? '0 : mem_data[rd_ptr];
  assign bus.o_addr  = fifo_empty ? '0 : mem_addr[rd_ptr];
  assign bus.o_mask  = fifo_empty ? '0 : mem_mask[rd_ptr];

  // A finished word moves to the stage register so the next beat can start lane 0 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane        <= '0;
      pack_data   <= '0;
      pack_mask   <= '0;
      stage_valid <= 1'b0;
      stage_flush <= 1'b0;
      stage_data  <= '0;
      stage_mask  <= '0;
    end else if (clear) begin
      lane        <= '0;
      pack_data   <= '0;
      pack_mask   <= '0;
      stage_valid <= 1'b0;
      stage_flush <= 1'b0;
    end else begin
      stage_valid <= load_stage;
      stage_flush <= load_stage && flush_take;
      if (load_stage) begin
        stage_data <= merged_data;
        stage_mask <= merged_mask;
        lane       <= '0;
        pack_data  <= '0;
        pack_mask  <= '0;
      end else if (beat) begin
        lane      <= lane + LANE_W'(1);
        pack_data <= merged_data;
        pack_mask <= merged_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_data[wr_ptr] <= stage_data;
      mem_addr[wr_ptr] <= addr;
      mem_mask[wr_ptr] <= stage_mask;
    end
  end

  // The address advances even for a dropped word so later words land where they belong.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      addr       <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      addr       <= base_addr;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (stage_valid) begin
        addr <= addr + ADDR_W'(1);
        if (!push_ok) begin
          overflow <= 1'b1;
        end
      end
      if (push_ok && word_count != 16'hFFFF) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only the word staged by the flush itself holds off done; stray DRAIN beats do not.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush) begin
          state_next = DRAIN;
        end else if (bus.in_valid) begin
          state_next = PACK;
        end
      end
      PACK: begin
        if (bus.flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !(stage_valid && stage_flush)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_packer.sv
// Scoreboard bench for wb_packer: a lane model queues expected words as beats are driven
// and a negedge monitor pops and compares them whenever the DMA side accepts a word.
module tb_wb_packer;
  localparam int BL    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [16*BL-1:0] data;
    logic [AW-1:0]    addr;
    logic [BL-1:0]    mask;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          overflow, done;
  logic [15:0]   word_count;

  wb_packer_if #(.BURST_LEN(BL), .ADDR_W(AW)) bus ();

  wb_packer #(.BURST_LEN(BL), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .base_addr  (base_addr),
    .bus        (bus),
    .overflow   (overflow),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  word_t sb[$];
  word_t mon_w;
  word_t new_w;
  int m_lane = 0;
  logic [16*BL-1:0] m_data = '0;
  logic [BL-1:0] m_mask = '0;
  logic [AW-1:0] m_addr = '0;
  int m_drop = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int pop_cyc = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sample away from the rising edge so o_ready and the FIFO head are settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst && bus.o_valid && bus.o_ready) begin
      pop_cyc = cyc;
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", 128'(sb.size()), 128'(1));
      end else begin
        mon_w = sb.pop_front();
        checkOutput("o_data", bus.o_data, mon_w.data);
        checkOutput("o_addr", 128'(bus.o_addr), 128'(mon_w.addr));
        checkOutput("o_mask", 128'(bus.o_mask), 128'(mon_w.mask));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic emitWord();
    if (m_drop > 0) begin
      m_drop--;
    end else begin
      new_w.data = m_data;
      new_w.addr = m_addr;
      new_w.mask = m_mask;
      sb.push_back(new_w);
    end
    m_addr = m_addr + AW'(1);
    m_data = '0;
    m_mask = '0;
    m_lane = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = f;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    if (v) begin
      m_data[m_lane*16 +: 16] = d;
      m_mask[m_lane] = 1'b1;
      m_lane++;
      if (m_lane == BL) emitWord();
    end
    if (f && m_mask != '0) emitWord();
  endtask

  task automatic resetModel(input logic [AW-1:0] b);
    sb.delete();
    m_lane = 0;
    m_data = '0;
    m_mask = '0;
    m_addr = b;
    m_drop = 0;
  endtask

  task automatic doClear(input logic [AW-1:0] b);
    clear = 1'b1;
    base_addr = b;
    step();
    clear = 1'b0;
    resetModel(b);
  endtask

  task automatic sendWords(input int n, input logic [15:0] seed);
    for (int i = 0; i < n * BL; i++) applyStimulus(1'b1, seed + 16'(i), 1'b0);
  endtask

  task automatic waitDrain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || bus.o_valid) && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.o_ready  = 1'b0;
    repeat (2) step();
    checkOutput("rst_o_valid", 128'(bus.o_valid), 128'(0));
    checkOutput("rst_o_data", bus.o_data, 128'(0));
    checkOutput("rst_o_addr", 128'(bus.o_addr), 128'(0));
    checkOutput("rst_o_mask", 128'(bus.o_mask), 128'(0));
    checkOutput("rst_overflow", 128'(overflow), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_word_count", 128'(word_count), 128'(0));
    rst = 1'b0;
    step();

    $display("[TB] single full word with latency check");
    doClear(10'h010);
    bus.o_ready = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("lat_cycle1_valid", 128'(bus.o_valid), 128'(0));
    step();
    checkOutput("lat_cycle2_valid", 128'(bus.o_valid), 128'(1));
    waitDrain(20);
    checkOutput("t1_word_count", 128'(word_count), 128'(1));

    $display("[TB] partial word on flush");
    doClear(10'h020);
    done_cnt = 0;
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitDrain(30);
    repeat (3) step();
    checkOutput("t2_done_pulses", 128'(done_cnt), 128'(1));
    checkOutput("t2_word_count", 128'(word_count), 128'(2));

    $display("[TB] overflow under backpressure");
    doClear(10'h040);
    bus.o_ready = 1'b0;
    sendWords(4, 16'h0200);
    m_drop = 1;
    sendWords(1, 16'h0300);
    repeat (3) step();
    checkOutput("t3_overflow", 128'(overflow), 128'(1));
    checkOutput("t3_word_count", 128'(word_count), 128'(4));
    checkOutput("t3_stall_addr", 128'(bus.o_addr), 128'(10'h040));
    checkOutput("t3_stall_data", bus.o_data, sb[0].data);
    step();
    checkOutput("t3_stall_data2", bus.o_data, sb[0].data);
    bus.o_ready = 1'b1;
    waitDrain(40);
    sendWords(1, 16'h0400);
    waitDrain(20);

    $display("[TB] address wrap");
    doClear(10'h3FF);
    sendWords(2, 16'h0500);
    waitDrain(30);
    checkOutput("t4_word_count", 128'(word_count), 128'(2));

    $display("[TB] flush together with the completing beat");
    doClear(10'h080);
    done_cnt = 0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h0600 + 16'(i), 1'b0);
    applyStimulus(1'b1, 16'h0607, 1'b1);
    waitDrain(20);
    repeat (3) step();
    checkOutput("t5_done_pulses", 128'(done_cnt), 128'(1));
    checkOutput("t5_done_after_pop", 128'(done_cyc > pop_cyc), 128'(1));
    checkOutput("t5_word_count", 128'(word_count), 128'(1));

    $display("[TB] clear mid-word with queued words");
    doClear(10'h100);
    bus.o_ready = 1'b0;
    sendWords(2, 16'h0700);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0800 + 16'(i), 1'b0);
    step();
    checkOutput("t6_pre_valid", 128'(bus.o_valid), 128'(1));
    checkOutput("t6_pre_word_count", 128'(word_count), 128'(2));
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    clear        = 1'b1;
    base_addr    = 10'h200;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    resetModel(10'h200);
    checkOutput("t6_o_valid", 128'(bus.o_valid), 128'(0));
    checkOutput("t6_overflow", 128'(overflow), 128'(0));
    checkOutput("t6_word_count", 128'(word_count), 128'(0));
    bus.o_ready = 1'b1;
    sendWords(1, 16'h0900);
    waitDrain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
